// File: rtl/rv32m_pkg.sv
// Shared constants and enums for the RV32M multiply/divide unit.
package rv32m_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_Q     = 32'h8000_0000;

endpackage

// File: rtl/rv32m_sign_fix.sv
// Final result selection: sign correction, half/quotient/remainder pick and
// divide special cases, applied to the raw magnitude result.
module rv32m_sign_fix
    import rv32m_pkg::*;
(
    input  muldiv_op_e  op,
    input  logic [63:0] raw,
    input  logic [31:0] a_mag,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        div_zero,
    input  logic        div_ovf,
    output logic [31:0] res
);

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] a_orig;

    // Divide raw layout is {remainder, quotient}.
    always_comb begin
        prod   = (sign_a ^ sign_b) ? -raw : raw;
        quo    = (sign_a ^ sign_b) ? -raw[31:0] : raw[31:0];
        rem    = sign_a ? -raw[63:32] : raw[63:32];
        a_orig = sign_a ? -a_mag : a_mag;
        res    = prod[63:32];
        case (op)
            OP_MUL:                       res = prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[63:32];
            OP_DIV, OP_DIVU:              res = div_zero ? DIV_BY_ZERO_Q :
                                                div_ovf  ? DIV_OVF_Q : quo;
            default:                      res = div_zero ? a_orig :
                                                div_ovf  ? 32'h0 : rem;
        endcase
    end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 34-cycle start-to-done latency.
//   state  | meaning
//   IDLE   | waiting for start; operands sampled on accept
//   CALC   | one shift-add / restoring-divide step per clock, 32 steps
//   FIX    | sign correction and special cases; result/rd_out load on exit
//   DONE   | one-cycle done strobe
module rv32m_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    import rv32m_pkg::*;

    localparam int CNT_W = $clog2(ITERS);

    muldiv_state_e     state, state_nxt;
    muldiv_op_e        op_q, op_in;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sign_a, sign_b, div_zero, div_ovf;
    logic [4:0]        rd_q;

    logic              accept, last_iter;
    logic              signed_a_in, signed_b_in, sa_in, sb_in, is_div_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic [XLEN:0]     mul_sum, div_top;
    logic [XLEN-1:0]   div_sub, div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_nxt, div_nxt;
    logic [XLEN-1:0]   fix_res;

    assign accept    = (state == S_IDLE) && start && !kill;
    assign last_iter = (cnt == CNT_W'(ITERS - 1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !kill) state_nxt = S_CALC;
            S_CALC: if (kill) state_nxt = S_IDLE;
                    else if (last_iter) state_nxt = S_FIX;
            S_FIX:  state_nxt = kill ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        op_in       = muldiv_op_e'(funct3);
        is_div_in   = funct3[2];
        signed_a_in = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV) || (op_in == OP_REM);
        signed_b_in = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                      (op_in == OP_DIV) || (op_in == OP_REM);
        sa_in       = signed_a_in && op_a[XLEN-1];
        sb_in       = signed_b_in && op_b[XLEN-1];
        mag_a_in    = sa_in ? -op_a : op_a;
        mag_b_in    = sb_in ? -op_b : op_b;
    end

    // Multiply shifts the product right through acc, low half seeded with the multiplier.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
        mul_nxt = {mul_sum, acc[XLEN-1:1]};
        div_top = acc[2*XLEN-1:XLEN-1];
        div_ge  = (div_top >= {1'b0, b_mag});
        div_sub = div_top[XLEN-1:0] - b_mag;
        div_rem = div_ge ? div_sub : div_top[XLEN-1:0];
        div_nxt = {div_rem, acc[XLEN-2:0], div_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            rd_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_in;
                rd_q     <= rd_in;
                cnt      <= '0;
                a_mag    <= mag_a_in;
                b_mag    <= mag_b_in;
                sign_a   <= sa_in;
                sign_b   <= sb_in;
                div_zero <= (op_b == '0);
                div_ovf  <= signed_b_in && is_div_in &&
                            (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
                acc      <= is_div_in ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
            end else if (state == S_CALC && !kill) begin
                acc <= op_q[2] ? div_nxt : mul_nxt;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == S_FIX && !kill) begin
                result <= fix_res;
                rd_out <= rd_q;
            end
        end
    end

    rv32m_sign_fix u_sign_fix (
        .op       (op_q),
        .raw      (acc),
        .a_mag    (a_mag),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .div_zero (div_zero),
        .div_ovf  (div_ovf),
        .res      (fix_res)
    );

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Scoreboard bench for rv32m_muldiv_unit: directed RV32M cases, random ops
// against an arithmetic reference, start-while-busy, kill and async reset.
module tb_rv32m_muldiv_unit;

    logic        clk, rst_n, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks   = 0;
    int failures = 0;
    logic [36:0] sb_q[$];
    logic [31:0] last_res = 32'h0;
    logic [4:0]  last_rd  = 5'd0;

    rv32m_muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .kill(kill),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] ua, ub, up;
        logic signed [31:0] as32, bs32, rs32;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        as32 = a;
        bs32 = b;
        ref_op = 32'h0;
        case (f)
            3'd0: begin sp = sa * sb; ref_op = sp[31:0]; end
            3'd1: begin sp = sa * sb; ref_op = sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); ref_op = sp[63:32]; end
            3'd3: begin up = ua * ub; ref_op = up[63:32]; end
            3'd4: begin
                if (b == 0) ref_op = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = 32'h8000_0000;
                else begin rs32 = as32 / bs32; ref_op = rs32; end
            end
            3'd5: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) ref_op = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = 32'h0;
                else begin rs32 = as32 % bs32; ref_op = rs32; end
            end
            default: ref_op = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issues one op; repulse/kill_at give the cycle (0 = none) for a stray start or a kill.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int repulse, input int kill_at);
        int done_cyc, ndone, busy_bad;
        logic expect_done, exp_busy;
        logic [36:0] ent;
        expect_done = (kill_at == 0);
        if (expect_done) sb_q.push_back({exp, rd});
        @(negedge clk);
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_before_start busy=%b required=0", name, busy);
        end
        checks++;
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        done_cyc = -1; ndone = 0; busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            exp_busy = (kill_at != 0) ? (c <= kill_at) : (c <= 34);
            if (busy !== exp_busy) busy_bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    if (expect_done && sb_q.size() > 0) begin
                        ent = sb_q.pop_front();
                        if (result !== ent[36:5]) begin
                            failures++;
                            $display("FAIL %s result got=%h required=%h", name, result, ent[36:5]);
                        end
                        if (rd_out !== ent[4:0]) begin
                            failures++;
                            $display("FAIL %s rd_out got=%0d required=%0d", name, rd_out, ent[4:0]);
                        end
                        checks += 2;
                    end
                end
            end
            if (c == repulse) begin
                start = 1'b1; op_a = 32'd9; op_b = 32'd9;
            end else begin
                start = 1'b0;
                if (c == 1) begin op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom); end
            end
            kill = (c == kill_at);
        end
        kill = 1'b0;
        if (busy_bad !== 0) begin
            failures++;
            $display("FAIL %s busy_window bad_cycles=%0d required=0", name, busy_bad);
        end
        checks++;
        if (expect_done) begin
            if (done_cyc < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
            if (done_cyc !== 34) begin
                failures++;
                $display("FAIL %s latency got=%0d required=34", name, done_cyc);
            end
            if (ndone !== 1) begin
                failures++;
                $display("FAIL %s done_pulses got=%0d required=1", name, ndone);
            end
            checks += 2;
            last_res = exp;
            last_rd  = rd;
        end else begin
            if (ndone !== 0) begin
                failures++;
                $display("FAIL %s killed_done_pulses got=%0d required=0", name, ndone);
            end
            if (result !== last_res || rd_out !== last_rd) begin
                failures++;
                $display("FAIL %s retained got=%h/%0d required=%h/%0d", name, result, rd_out, last_res, last_rd);
            end
            checks += 2;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; funct3 = 3'd0;
        op_a = 32'h0; op_b = 32'h0; rd_in = 5'd0;
        #1;
        if ({busy, done, result, rd_out} !== 39'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%h/%0d required=0/0/0/0", busy, done, result, rd_out);
        end
        checks++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0, 0);
        run_op("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 0, 0);
        run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 0, 0);
        run_op("mulhsu_ones",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 0, 0);
    endtask

    task automatic test_div();
        run_op("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFD, 0, 0);
        run_op("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 0, 0);
        run_op("divu_100_7", 3'd5, 32'd100,       32'd7, 5'd11, 32'd14,        0, 0);
        run_op("remu_100_7", 3'd7, 32'd100,       32'd7, 5'd0,  32'd2,         0, 0);
    endtask

    task automatic test_special();
        run_op("divu_by0", 3'd5, 32'h1234,      32'h0,         5'd12, 32'hFFFF_FFFF, 0, 0);
        run_op("remu_by0", 3'd7, 32'h1234,      32'h0,         5'd13, 32'h1234,      0, 0);
        run_op("rem_by0",  3'd6, 32'hFFFF_FF00, 32'h0,         5'd14, 32'hFFFF_FF00, 0, 0);
        run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0, 0);
        run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0,         0, 0);
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f = 3'(i % 8);
            a = $urandom;
            b = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (i % 3 == 0) b = {{16{b[15]}}, b[15:0]};
            run_op("random", f, a, b, 5'(i + 1), ref_op(f, a, b), 0, 0);
        end
    endtask

    task automatic test_back_to_back();
        run_op("busy_restart", 3'd0, 32'd3, 32'd4, 5'd17, 32'd12, 10, 0);
    endtask

    task automatic test_kill();
        run_op("kill_div", 3'd4, 32'd1000, 32'd3, 5'd18, 32'h0, 0, 20);
        run_op("after_kill", 3'd5, 32'd1000, 32'd3, 5'd19, 32'd333, 0, 0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; op_a = 32'd77; op_b = 32'd5; rd_in = 5'd20;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        if ({busy, done, result, rd_out} !== 39'h0) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%h/%0d required=0/0/0/0", busy, done, result, rd_out);
        end
        checks++;
        last_res = 32'h0;
        last_rd  = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset", 3'd6, 32'd77, 32'd5, 5'd21, 32'd2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_random();
        test_async_reset();
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32m_muldiv_unit.md
Name: rv32m_muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, a neighbouring stage of the register file. Operands come from read ports RD1/RD2. The unit produces a 32-bit result and destination index that the writeback path steers onto WD3/A3 with WE3. It uses a fixed-latency start/busy/done handshake, so control stalls the single-cycle core while an M-extension instruction is in flight.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, 32, radix-2 iterations per operation; must equal XLEN.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  32  rs1 value (RD1)
op_b  input  32  rs2 value (RD2)
rd_in  input  5  destination register index
kill  input  1  synchronous abort of in-flight operation
busy  output  1  high in CALC, FIX, DONE
done  output  1  one-cycle result-valid strobe
result  output  32  registered result
rd_out  output  5  registered destination index, paired with result

Behaviour:
- Reset is asynchronous, from rst_n low, with no clock required. All of the following go to 0: state (IDLE), busy, done, result, rd_out, counter, accumulators.
- FSM has four states: IDLE, CALC, FIX, DONE.
  - IDLE & start & !kill -> CALC. On this transition the unit latches funct3 and rd_in, takes operand magnitudes, records the sign flags and sets cnt=0.
  - CALC: one iteration per edge. After the edge with cnt==31 the state moves to FIX.
  - FIX: applies sign correction and selects the low or high half or the quotient/remainder. The result and rd_out registers load on the FIX->DONE edge.
  - DONE: done=1 for exactly one cycle, then the state returns to IDLE.
- Latency is fixed: the start cycle is cycle 0 and done is high in cycle 34. There is no early-out. Divide-by-zero and overflow also take 34 cycles.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Multiply: unsigned shift-add on magnitudes into a 64-bit product. The product is negated if the sign flags differ. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring division on magnitudes.
  - Quotient is negated if the sign flags differ.
  - Remainder takes the sign of the dividend.
- Special cases, decided in FIX:
  - Divisor 0: quotient is 0xFFFFFFFF; remainder is op_a, for both signed and unsigned ops.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient is 0x80000000; remainder is 0.
- start while busy is ignored. Operands are not re-sampled and there is no error flag.
- start and done in the same cycle: not possible, because done only occurs in DONE and start is accepted only in IDLE. A start asserted during DONE is ignored; it must be held until IDLE.
- kill:
  - In CALC or FIX, kill forces IDLE on the next edge. No done pulse occurs, and result and rd_out keep their previous values.
  - In DONE, kill has no effect; the done pulse still occurs.
  - In IDLE, kill has priority over start.
- result and rd_out hold stable from done until the FIX->DONE edge of the next accepted operation.
- rd_in == 0: the unit computes normally. Dropping the write is the register file's job.
- op_a and op_b are don't-care after the accepting edge.

Decomposition:
- rv32m_pkg holds:
  - XLEN constant.
  - funct3 enum (muldiv_op_e).
  - FSM state enum (muldiv_state_e).
  - DIV_BY_ZERO_Q constant, 32'hFFFFFFFF.
  - DIV_OVF_Q constant, 32'h80000000.
- One sub-module is natural: rv32m_sign_fix, purely combinational, used in FIX. It takes the 64-bit raw product or quotient/remainder, the sign flags, funct3 and the special-case flags, and returns the final 32-bit value.
- The FSM and datapath registers stay in rv32m_muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD, rd_in=5 -> done in cycle 34, result 0xFFFFFFEB, rd_out 5, busy cycles 1-34. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 % 7 -> 2.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 — all with 34-cycle latency.
- Start MUL 3x4, re-pulse start with 9x9 in cycle 10 -> 9x9 ignored, single done in cycle 34 with result 12.
- Start DIV, assert kill in cycle 20 -> IDLE at cycle 21, no done, prior result retained. Separately, drop rst_n in cycle 15 -> all outputs 0 immediately, then a new op completes normally.
